// File: rtl/encoder32to5_stream_if.sv
// Handshake bundle for the 32-to-5 streaming encoder: vector input side and index output side.
interface encoder32to5_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic [5:0]  out_count;
  logic        zero_pulse;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_count, zero_pulse
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_count, zero_pulse
  );
endinterface

// File: rtl/encoder32to5_stream.sv
// Sequential 32-to-5 encoder: captures a multi-hot vector, then streams the index of
// every set bit in ascending order, one per output handshake.
module encoder32to5_stream (
  input logic                          clk,
  input logic                          rst,
  encoder32to5_stream_if.slave         bus_io
);
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [5:0]  count_q, count_d;
  logic        zero_q, zero_d;

  logic [31:0] lsb_onehot;
  logic [4:0]  idx_terms [32];
  logic [4:0]  low_idx;
  logic        single_bit;
  logic [5:0]  vec_popcount;
  logic        emit_active;

  // Isolate the lowest set bit, then OR together the positions of the one-hot terms.
  assign lsb_onehot = pending_q & (~pending_q + 32'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_idx_term
      assign idx_terms[gi] = lsb_onehot[gi] ? 5'(gi) : 5'd0;
    end
  endgenerate

  always_comb begin
    low_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      low_idx = low_idx | idx_terms[i];
    end
  end

  always_comb begin
    vec_popcount = 6'd0;
    for (int i = 0; i < 32; i++) begin
      vec_popcount = vec_popcount + 6'(bus_io.in_vec[i]);
    end
  end

  assign single_bit  = (pending_q != 32'd0) && ((pending_q & (pending_q - 32'd1)) == 32'd0);
  assign emit_active = (state_q == EMIT);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    zero_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          if (bus_io.in_vec != 32'd0) begin
            pending_d = bus_io.in_vec;
            count_d   = vec_popcount;
            state_d   = EMIT;
          end else begin
            count_d = 6'd0;
            zero_d  = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus_io.out_ready) begin
          pending_d = pending_q & (pending_q - 32'd1);
          if (single_bit) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 32'd0;
      count_q   <= 6'd0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
    end
  end

  assign bus_io.in_ready   = (state_q == IDLE);
  assign bus_io.out_valid  = emit_active;
  assign bus_io.out_idx    = emit_active ? low_idx : 5'd0;
  assign bus_io.out_last   = emit_active & single_bit;
  assign bus_io.out_count  = count_q;
  assign bus_io.zero_pulse = zero_q;
endmodule

// File: tb/tb_encoder32to5_stream.sv
// Randomized bench for encoder32to5_stream: each vector's expected beats are the ascending
// list of its set-bit positions, compared beat by beat under random backpressure.
module tb_encoder32to5_stream;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  encoder32to5_stream_if bus ();

  encoder32to5_stream dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one vector, then walks the expected index list; bp cycles of forced stall first.
  task automatic send_vec(input logic [31:0] vec, input int bp, input bit rnd_ready);
    int   q[$];
    int   cnt;
    int   cyc;
    int   beats;
    logic rdy;
    check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_vec    = vec;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_vec   = $urandom;
    cnt = $countones(vec);
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) q.push_back(i);
    end
    if (q.size() == 0) begin
      check_eq("zero_pulse_hi", 32'(bus.zero_pulse), 32'd1);
      check_eq("zero_no_valid", 32'(bus.out_valid), 32'd0);
      check_eq("zero_count", 32'(bus.out_count), 32'd0);
      check_eq("zero_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      check_eq("zero_pulse_lo", 32'(bus.zero_pulse), 32'd0);
      check_eq("zero_no_valid2", 32'(bus.out_valid), 32'd0);
      $display("vec %08h zero vector", vec);
      return;
    end
    cyc   = 0;
    beats = 0;
    while (q.size() > 0 && cyc < 300) begin
      if (cyc < bp)       rdy = 1'b0;
      else if (rnd_ready) rdy = ($urandom_range(0, 2) != 0);
      else                rdy = 1'b1;
      bus.out_ready = rdy;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_vec    = $urandom | 32'h1;
      check_eq("out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("in_ready_busy", 32'(bus.in_ready), 32'd0);
      check_eq("out_idx", 32'(bus.out_idx), 32'(q[0]));
      check_eq("out_last", 32'(bus.out_last), 32'(q.size() == 1));
      check_eq("out_count", 32'(bus.out_count), 32'(cnt));
      step();
      if (rdy) begin
        void'(q.pop_front());
        beats++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_eq("beats_left", 32'(q.size()), 32'd0);
    check_eq("idle_valid", 32'(bus.out_valid), 32'd0);
    check_eq("idle_ready", 32'(bus.in_ready), 32'd1);
    check_eq("idle_idx", 32'(bus.out_idx), 32'd0);
    check_eq("idle_last", 32'(bus.out_last), 32'd0);
    check_eq("idle_count", 32'(bus.out_count), 32'(cnt));
    $display("vec %08h beats %0d count %0d cycles %0d", vec, beats, cnt, cyc);
  endtask

  function automatic logic [31:0] rand_vec();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = 32'd0;
      1: v = 32'h1 << $urandom_range(0, 31);
      2: v = $urandom & $urandom & $urandom;
      3: v = $urandom | $urandom;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] v;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_vec    = 32'h0000_00F0;
    bus.out_ready = 1'b1;

    // Reset held with a vector offered: nothing may be captured.
    step();
    step();
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_idx", 32'(bus.out_idx), 32'd0);
    check_eq("rst_count", 32'(bus.out_count), 32'd0);
    check_eq("rst_zero", 32'(bus.zero_pulse), 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_valid2", 32'(bus.out_valid), 32'd0);

    send_vec(32'h0000_0100, 0, 1'b0);
    send_vec(32'h8000_0005, 0, 1'b0);
    send_vec(32'h0000_0003, 3, 1'b0);
    send_vec(32'h0000_0000, 0, 1'b0);
    send_vec(32'h8000_0000, 0, 1'b0);
    send_vec(32'hFFFF_FFFF, 0, 1'b0);

    // Abort a full vector after four beats.
    send_vec(32'h0000_0000, 0, 1'b0);
    check_eq("mid_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_vec    = 32'hFFFF_FFFF;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("mid_idx", 32'(bus.out_idx), 32'(i));
      check_eq("mid_valid", 32'(bus.out_valid), 32'd1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_zero", 32'(bus.zero_pulse), 32'd0);
    check_eq("mid_rst_count", 32'(bus.out_count), 32'd0);
    step();
    check_eq("mid_post_valid", 32'(bus.out_valid), 32'd0);
    $display("vec ffffffff aborted by reset after 4 beats");
    send_vec(32'h0001_0000, 0, 1'b0);

    // Round trip against decoder outputs.
    for (int a = 0; a < 32; a++) begin
      v = 32'h1 << a;
      send_vec(v, 0, 1'b0);
    end

    for (int n = 0; n < 60; n++) begin
      v = rand_vec();
      send_vec(v, $urandom_range(0, 2), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/encoder32to5_stream.md
Name: encoder32to5_stream

Overview:
Sequential 32-to-5 encoder, the inverse direction of the 5-to-32 decoder. It accepts a 32-bit multi-hot vector over a valid/ready handshake, then emits the 5-bit index of every set bit, in ascending order, one index per accepted output handshake. It serves as the index source that feeds the 5-to-32 decoder and mux32to1 select paths, and it is the round-trip partner for decoder verification.

Parameters:
N, 32, input vector width. Fixed at 32 for this block; no other value is supported.
W, 5, index width; equals clog2(N).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_vec is valid this cycle
in_ready  output  1  block can accept a vector; high only in IDLE
in_vec  input  32  multi-hot request vector
out_valid  output  1  out_idx is valid
out_ready  input  1  consumer accepts out_idx this cycle
out_idx  output  5  index of the lowest pending set bit
out_last  output  1  out_idx is the final index for the current vector
out_count  output  6  popcount of the captured vector (0..32), held until the next accept
zero_pulse  output  1  one-cycle pulse when an all-zero vector is accepted

Behaviour:
- Reset (rst high at a clk edge):
  - state goes to IDLE and the pending register is cleared.
  - out_valid=0, out_idx=0, out_last=0, out_count=0, zero_pulse=0.
  - in_ready=1 from the cycle after the reset edge.
- State machine:
  - Two states: IDLE and EMIT.
  - in_ready = (state==IDLE).
  - out_valid = (state==EMIT).
- IDLE, accept = in_valid & in_ready, with in_vec != 0:
  - Load pending <= in_vec.
  - Load out_count <= popcount(in_vec).
  - Go to EMIT.
  - out_valid rises on the cycle after the accept edge (latency 1).
- IDLE, accept with in_vec == 0:
  - Stay in IDLE.
  - out_count <= 0.
  - zero_pulse=1 for exactly the next cycle.
  - No output beat is produced.
- EMIT outputs (combinational from the pending register):
  - out_idx = lowest set bit position of pending.
  - out_last = 1 iff exactly one bit of pending is set.
- EMIT, out handshake (out_valid & out_ready):
  - Clear the lowest set bit of pending.
  - If out_last, go to IDLE.
  - Otherwise, the next index appears the following cycle.
  - Throughput is 1 index per cycle while out_ready is held high.
- Backpressure: while out_ready=0, out_idx, out_last and pending hold stable.
- Output gating: out_idx and out_last are forced to 0 whenever out_valid=0.
- in_valid during EMIT: ignored, since in_ready=0. The upstream must hold its vector.
- Vector-to-vector bubble: exactly one cycle. IDLE is always visited between vectors.
- Boundary cases:
  - bit 31 alone gives idx=31 with last=1.
  - 32'hFFFFFFFF gives 32 beats, idx 0..31, with last on 31 and out_count=32.
- Reset mid-EMIT: remaining indices are discarded, with no further output beats. zero_pulse is cleared.
- rst has priority over every handshake in the same cycle.

Test Plan:
1. Reset: rst=1 for 2 cycles, in_valid=1 -> out_valid=0, out_idx=0, out_count=0, zero_pulse=0 during reset. in_ready=1 after the first edge with rst low.
2. One-hot: in_vec=32'h00000100, out_ready=1 -> next cycle out_valid=1, out_idx=8, out_last=1, out_count=1. The cycle after, in_ready=1 and out_valid=0.
3. Multi-hot in order: in_vec=32'h80000005, out_ready=1 -> out_idx 0, 2, 31 on three consecutive cycles, out_last only on 31, out_count=3.
4. Backpressure: in_vec=32'h00000003 with out_ready=0 for 3 cycles -> out_idx=0 held stable. Then out_ready=1 gives 0 then 1 (last). An in_valid offered during EMIT is not accepted.
5. Zero vector: in_vec=0 accepted -> zero_pulse=1 for one cycle, out_valid stays 0, out_count=0, in_ready stays 1.
6. Reset mid-operation and round trip:
   - in_vec=32'hFFFFFFFF; after 4 beats (idx 0..3) assert rst -> out_valid=0 next cycle, and the next vector 32'h00010000 yields idx=16 only.
   - Round trip: feed each decoder5to32 output for A=0..31 -> out_idx==A, out_last=1.
